// File: rtl/floating_point_div.sv
// floating_point_div
//   Iterative IEEE-754 divider (default binary32), round-to-nearest-even.
//   One quotient bit per cycle and one operation in flight. The result
//   appears FRAC_WIDTH+6 edges after the accepting edge. Special operands
//   travel through the same states so that the latency never changes.
//
// Ports
//   clkIn       clock, rising edge
//   rstIn       asynchronous active-low reset
//   dataAIn     dividend {sign, exp, mantissa}
//   dataBIn     divisor
//   validIn     operand strobe, accepted while readyOut=1
//   readyOut    block is idle and can accept an operation
//   dataOut     quotient, held until the next result
//   validOut    one-cycle result strobe
//   divZeroOut  finite nonzero / zero, qualified by validOut
//
// state | meaning
// ------+--------------------------------------------------------------
// IDLE  | readyOut=1, operands captured on validIn
// PREP  | unpack, normalise subnormals, classify specials, form exponent
// DIV   | restoring division, FRAC_WIDTH+3 quotient bits
// NORM  | one-bit normalise, right shift into the subnormal range
// ROUND | round to nearest even, pack, pulse validOut
module floating_point_div #(
    parameter int  FRAC_WIDTH = 24,
    parameter int  EXP_WIDTH  = 8,
    localparam int DATA_WIDTH = FRAC_WIDTH + EXP_WIDTH
) (
    input  logic                  clkIn,
    input  logic                  rstIn,
    input  logic [DATA_WIDTH-1:0] dataAIn,
    input  logic [DATA_WIDTH-1:0] dataBIn,
    input  logic                  validIn,
    output logic                  readyOut,
    output logic [DATA_WIDTH-1:0] dataOut,
    output logic                  validOut,
    output logic                  divZeroOut
);

    localparam int MAN_W   = FRAC_WIDTH - 1;
    localparam int QW      = FRAC_WIDTH + 3;
    localparam int SE_W    = EXP_WIDTH + 2;
    localparam int CNT_W   = $clog2(FRAC_WIDTH + 3);
    localparam int LZ_W    = $clog2(FRAC_WIDTH);
    localparam int SH_W    = $clog2(QW);
    localparam int BIAS    = 2**(EXP_WIDTH-1) - 1;
    localparam int EXP_MAX = 2**EXP_WIDTH - 1;

    typedef enum logic [2:0] {S_IDLE, S_PREP, S_DIV, S_NORM, S_ROUND} state_t;

    typedef struct packed {
        logic [FRAC_WIDTH-1:0] sig;
        logic [SE_W-1:0]       exp;
    } unpacked_t;

    state_t                 state_q, state_d;
    logic [DATA_WIDTH-1:0]  op_a_q, op_a_d, op_b_q, op_b_d;
    logic                   sign_q, sign_d;
    logic [SE_W-1:0]        exp_q, exp_d;
    logic [FRAC_WIDTH-1:0]  sig_b_q, sig_b_d;
    logic [FRAC_WIDTH:0]    rem_q, rem_d;
    logic [QW-1:0]          quo_q, quo_d;
    logic [CNT_W-1:0]       cnt_q, cnt_d;
    logic                   sticky_q, sticky_d;
    logic                   nan_q, nan_d, inf_q, inf_d, zero_q, zero_d, dz_q, dz_d;
    logic [DATA_WIDTH-1:0]  data_out_q, data_out_d;
    logic                   div_zero_out_q, div_zero_out_d;
    logic                   valid_out_q, valid_out_d;

    // leading-zero count of a significand (priority encoder)
    function automatic logic [LZ_W-1:0] lzc(input logic [FRAC_WIDTH-1:0] v);
        logic [LZ_W-1:0] n;
        n = '0;
        for (int i = 0; i < FRAC_WIDTH; i++) begin
            if (v[i]) n = LZ_W'(FRAC_WIDTH - 1 - i);
        end
        return n;
    endfunction

    // subnormals get implicit bit 0 and effective exponent 1, then are
    // left-aligned so the divider always sees a significand in [1,2)
    function automatic unpacked_t unpack(input logic [DATA_WIDTH-1:0] v);
        unpacked_t             u;
        logic [EXP_WIDTH-1:0]  e;
        logic [EXP_WIDTH-1:0]  e_eff;
        logic [FRAC_WIDTH-1:0] s;
        logic [LZ_W-1:0]       lz;
        e     = v[DATA_WIDTH-2 -: EXP_WIDTH];
        e_eff = (e == '0) ? EXP_WIDTH'(1) : e;
        s     = {(e != '0), v[MAN_W-1:0]};
        lz    = lzc(s);
        u.sig = s << lz;
        u.exp = {2'b00, e_eff} - {{(SE_W-LZ_W){1'b0}}, lz};
        return u;
    endfunction

    // ---------------- PREP datapath ----------------
    unpacked_t       ua, ub;
    logic [SE_W-1:0] exp_div;
    logic            a_nan, a_inf, a_zero, b_nan, b_inf, b_zero;

    always_comb begin
        logic a_ones, b_ones, a_man, b_man;
        ua      = unpack(op_a_q);
        ub      = unpack(op_b_q);
        exp_div = ua.exp - ub.exp + SE_W'(BIAS);
        a_ones  = &op_a_q[DATA_WIDTH-2 -: EXP_WIDTH];
        b_ones  = &op_b_q[DATA_WIDTH-2 -: EXP_WIDTH];
        a_man   = |op_a_q[MAN_W-1:0];
        b_man   = |op_b_q[MAN_W-1:0];
        a_nan   = a_ones & a_man;
        a_inf   = a_ones & ~a_man;
        a_zero  = ~(|op_a_q[DATA_WIDTH-2:0]);
        b_nan   = b_ones & b_man;
        b_inf   = b_ones & ~b_man;
        b_zero  = ~(|op_b_q[DATA_WIDTH-2:0]);
    end

    // ---------------- DIV datapath ----------------
    logic                div_ge;
    logic [FRAC_WIDTH:0] rem_sub;

    always_comb begin
        div_ge  = rem_q >= {1'b0, sig_b_q};
        rem_sub = div_ge ? (rem_q - {1'b0, sig_b_q}) : rem_q;
    end

    // ---------------- NORM datapath ----------------
    logic [QW-1:0]   norm_q1, norm_q2;
    logic [SE_W-1:0] norm_e1, norm_e2, norm_sh_full;
    logic [SH_W-1:0] norm_sh;
    logic [2*QW-1:0] norm_ext;
    logic            norm_lost;

    always_comb begin
        norm_q1      = quo_q[QW-1] ? quo_q : {quo_q[QW-2:0], 1'b0};
        norm_e1      = quo_q[QW-1] ? exp_q : exp_q - SE_W'(1);
        norm_sh_full = SE_W'(1) - norm_e1;
        norm_sh      = (norm_sh_full > SE_W'(QW-1)) ? SH_W'(QW-1) : SH_W'(norm_sh_full);
        norm_ext     = {norm_q1, {QW{1'b0}}} >> norm_sh;
        norm_q2      = norm_q1;
        norm_e2      = norm_e1;
        norm_lost    = 1'b0;
        // exponent <= 0: move into the subnormal range, keep lost bits as sticky
        if (norm_e1[SE_W-1] || (norm_e1 == '0)) begin
            norm_q2   = norm_ext[2*QW-1:QW];
            norm_lost = |norm_ext[QW-1:0];
            norm_e2   = '0;
        end
    end

    // ---------------- ROUND datapath ----------------
    logic [MAN_W:0]        rnd_sum;
    logic [SE_W-1:0]       rnd_exp;
    logic                  rnd_up, rnd_ovf;
    logic [DATA_WIDTH-1:0] rnd_pack;

    always_comb begin
        // q[QW-1] implicit, q[QW-2:3] mantissa, q[2] guard, q[1:0] sticky
        rnd_up  = quo_q[2] & (quo_q[3] | quo_q[1] | quo_q[0] | sticky_q);
        rnd_sum = {1'b0, quo_q[QW-2:3]} + {{MAN_W{1'b0}}, rnd_up};
        // mantissa carry bumps the exponent (also subnormal -> normal)
        rnd_exp = exp_q + {{(SE_W-1){1'b0}}, rnd_sum[MAN_W]};
        rnd_ovf = ~rnd_exp[SE_W-1] & (rnd_exp >= SE_W'(EXP_MAX));
        if (nan_q) begin
            rnd_pack = {1'b0, {EXP_WIDTH{1'b1}}, 1'b1, {(MAN_W-1){1'b0}}};
        end else if (inf_q || (!zero_q && rnd_ovf)) begin
            rnd_pack = {sign_q, {EXP_WIDTH{1'b1}}, {MAN_W{1'b0}}};
        end else if (zero_q) begin
            rnd_pack = {sign_q, {(DATA_WIDTH-1){1'b0}}};
        end else begin
            rnd_pack = {sign_q, rnd_exp[EXP_WIDTH-1:0], rnd_sum[MAN_W-1:0]};
        end
    end

    // ---------------- FSM ----------------
    always_comb begin
        state_d        = state_q;
        op_a_d         = op_a_q;
        op_b_d         = op_b_q;
        sign_d         = sign_q;
        exp_d          = exp_q;
        sig_b_d        = sig_b_q;
        rem_d          = rem_q;
        quo_d          = quo_q;
        cnt_d          = cnt_q;
        sticky_d       = sticky_q;
        nan_d          = nan_q;
        inf_d          = inf_q;
        zero_d         = zero_q;
        dz_d           = dz_q;
        data_out_d     = data_out_q;
        div_zero_out_d = div_zero_out_q;
        valid_out_d    = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (validIn) begin
                    op_a_d  = dataAIn;
                    op_b_d  = dataBIn;
                    state_d = S_PREP;
                end
            end
            S_PREP: begin
                sign_d  = op_a_q[DATA_WIDTH-1] ^ op_b_q[DATA_WIDTH-1];
                exp_d   = exp_div;
                sig_b_d = ub.sig;
                rem_d   = {1'b0, ua.sig};
                quo_d   = '0;
                cnt_d   = CNT_W'(FRAC_WIDTH + 2);
                nan_d   = a_nan | b_nan | (a_zero & b_zero) | (a_inf & b_inf);
                inf_d   = ~nan_d & (a_inf | b_zero);
                dz_d    = ~nan_d & ~a_inf & b_zero;
                zero_d  = ~nan_d & ~inf_d & (a_zero | b_inf);
                state_d = S_DIV;
            end
            S_DIV: begin
                rem_d = rem_sub << 1;
                quo_d = {quo_q[QW-2:0], div_ge};
                if (cnt_q == '0) begin
                    state_d = S_NORM;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            S_NORM: begin
                quo_d    = norm_q2;
                exp_d    = norm_e2;
                sticky_d = (|rem_q) | norm_lost;
                state_d  = S_ROUND;
            end
            S_ROUND: begin
                data_out_d     = rnd_pack;
                div_zero_out_d = dz_q;
                valid_out_d    = 1'b1;
                state_d        = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clkIn or negedge rstIn) begin
        if (!rstIn) begin
            state_q        <= S_IDLE;
            op_a_q         <= '0;
            op_b_q         <= '0;
            sign_q         <= 1'b0;
            exp_q          <= '0;
            sig_b_q        <= '0;
            rem_q          <= '0;
            quo_q          <= '0;
            cnt_q          <= '0;
            sticky_q       <= 1'b0;
            nan_q          <= 1'b0;
            inf_q          <= 1'b0;
            zero_q         <= 1'b0;
            dz_q           <= 1'b0;
            data_out_q     <= '0;
            div_zero_out_q <= 1'b0;
            valid_out_q    <= 1'b0;
        end else begin
            state_q        <= state_d;
            op_a_q         <= op_a_d;
            op_b_q         <= op_b_d;
            sign_q         <= sign_d;
            exp_q          <= exp_d;
            sig_b_q        <= sig_b_d;
            rem_q          <= rem_d;
            quo_q          <= quo_d;
            cnt_q          <= cnt_d;
            sticky_q       <= sticky_d;
            nan_q          <= nan_d;
            inf_q          <= inf_d;
            zero_q         <= zero_d;
            dz_q           <= dz_d;
            data_out_q     <= data_out_d;
            div_zero_out_q <= div_zero_out_d;
            valid_out_q    <= valid_out_d;
        end
    end

    assign readyOut   = (state_q == S_IDLE);
    assign dataOut    = data_out_q;
    assign validOut   = valid_out_q;
    assign divZeroOut = div_zero_out_q;

endmodule

// File: tb/tb_floating_point_div.sv
// tb_floating_point_div
//   Directed table, control-path sequences and random operands for the
//   binary32 configuration of floating_point_div. Random expectations come
//   from an exact wide-integer division rounded to nearest even.
module tb_floating_point_div;

    localparam int LAT = 30;   // edges from the accepting edge to the validOut edge
    localparam int TMO = 100;

    logic        clkIn = 1'b0;
    logic        rstIn;
    logic [31:0] dataAIn, dataBIn;
    logic        validIn;
    logic        readyOut;
    logic [31:0] dataOut;
    logic        validOut;
    logic        divZeroOut;

    int errors = 0;
    int checks = 0;

    always #5 clkIn = ~clkIn;

    floating_point_div dut (
        .clkIn      (clkIn),
        .rstIn      (rstIn),
        .dataAIn    (dataAIn),
        .dataBIn    (dataBIn),
        .validIn    (validIn),
        .readyOut   (readyOut),
        .dataOut    (dataOut),
        .validOut   (validOut),
        .divZeroOut (divZeroOut)
    );

    typedef struct {
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] q;
        logic        dz;
    } vec_t;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // exact quotient via wide integer division, then round-to-nearest-even
    function automatic logic [31:0] model_div(input logic [31:0] a, input logic [31:0] b,
                                              output logic dz);
        logic         s, a_nan, b_nan, a_inf, b_inf, a_zero, b_zero, guard, sticky;
        int           xa, xb, ea, eb, base, p, top, lsb, shift, be;
        logic [23:0]  ma, mb;
        logic [255:0] num, den, quo, rem, low;
        logic [24:0]  mant;
        dz     = 1'b0;
        s      = a[31] ^ b[31];
        xa     = int'(a[30:23]);
        xb     = int'(b[30:23]);
        a_nan  = (xa == 255) && (a[22:0] != 0);
        b_nan  = (xb == 255) && (b[22:0] != 0);
        a_inf  = (xa == 255) && (a[22:0] == 0);
        b_inf  = (xb == 255) && (b[22:0] == 0);
        a_zero = (a[30:0] == 0);
        b_zero = (b[30:0] == 0);
        if (a_nan || b_nan || (a_zero && b_zero) || (a_inf && b_inf)) return 32'h7FC00000;
        if (a_inf) return {s, 8'hFF, 23'h0};
        if (b_zero) begin
            dz = 1'b1;
            return {s, 8'hFF, 23'h0};
        end
        if (a_zero || b_inf) return {s, 31'h0};
        ma   = {(xa != 0), a[22:0]};
        mb   = {(xb != 0), b[22:0]};
        ea   = ((xa == 0) ? 1 : xa) - 150;
        eb   = ((xb == 0) ? 1 : xb) - 150;
        num  = 256'(ma) << 100;
        den  = 256'(mb);
        quo  = num / den;
        rem  = num % den;
        base = ea - eb - 100;
        p    = 0;
        for (int i = 0; i < 256; i++) if (quo[i]) p = i;
        top   = p + base;
        lsb   = (top - 23 < -149) ? -149 : top - 23;
        shift = lsb - base;
        mant  = 25'(quo >> shift);
        guard = quo[shift-1];
        low   = quo & ((256'(1) << (shift - 1)) - 256'(1));
        sticky = (rem != 0) || (low != 0);
        if (guard && (mant[0] || sticky)) mant = mant + 25'd1;
        if (top >= -126) begin
            be = top + 127;
            if (mant[24]) begin
                mant = mant >> 1;
                be++;
            end
            if (be >= 255) return {s, 8'hFF, 23'h0};
            return {s, 8'(be), mant[22:0]};
        end
        return {s, 7'h0, mant[23], mant[22:0]};
    endfunction

    function automatic logic [31:0] rand_op();
        logic [31:0] r;
        logic [7:0]  e;
        r = $urandom;
        case ($urandom_range(0, 9))
            0:          e = r[30:23];
            1, 2, 3, 4: e = 8'($urandom_range(110, 144));
            5:          e = ($urandom_range(0, 1) == 1) ? 8'($urandom_range(1, 20))
                                                        : 8'($urandom_range(235, 254));
            6:          e = 8'h00;
            7: begin e = 8'h00; r[22:0] = '0; end
            8: begin e = 8'hFF; r[22:0] = '0; end
            default: begin e = 8'hFF; r[0] = 1'b1; end
        endcase
        return {r[31], e, r[22:0]};
    endfunction

    task automatic wait_ready(input string tag);
        int n;
        n = 0;
        while (readyOut !== 1'b1 && n < TMO) begin
            @(negedge clkIn);
            n++;
        end
        check({tag, " ready_wait"}, 32'(readyOut), 32'd1);
    endtask

    // called at the negedge just after the accepting edge (lat=0 there)
    task automatic wait_valid(output int lat, output logic rdy_seen);
        lat = 0;
        rdy_seen = 1'b0;
        while (validOut !== 1'b1 && lat < TMO) begin
            if (readyOut) rdy_seen = 1'b1;
            @(negedge clkIn);
            lat++;
        end
    endtask

    task automatic run_op(input logic [31:0] a, input logic [31:0] b,
                          input logic [31:0] q, input logic dz, input string tag);
        int   lat;
        logic rdy;
        wait_ready(tag);
        dataAIn = a;
        dataBIn = b;
        validIn = 1'b1;
        @(negedge clkIn);
        validIn = 1'b0;
        dataAIn = $urandom;
        dataBIn = $urandom;
        wait_valid(lat, rdy);
        check({tag, " latency"},   32'(lat), 32'(LAT));
        check({tag, " ready_low"}, 32'(rdy), 32'd0);
        check({tag, " data"},      dataOut, q);
        check({tag, " div_zero"},  32'(divZeroOut), 32'(dz));
        @(negedge clkIn);
        check({tag, " pulse"},     32'(validOut), 32'd0);
        check({tag, " hold"},      dataOut, q);
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        vec_t        vecs[$];
        logic [31:0] a, b, q;
        logic        dz, rdy;
        int          lat, pulses;

        vecs.push_back('{32'h40C00000, 32'h40000000, 32'h40400000, 1'b0});
        vecs.push_back('{32'h3F800000, 32'h40400000, 32'h3EAAAAAB, 1'b0});
        vecs.push_back('{32'hBF800000, 32'h40400000, 32'hBEAAAAAB, 1'b0});
        vecs.push_back('{32'h3F800000, 32'h00000000, 32'h7F800000, 1'b1});
        vecs.push_back('{32'h00000000, 32'h00000000, 32'h7FC00000, 1'b0});
        vecs.push_back('{32'h7F800000, 32'h7F800000, 32'h7FC00000, 1'b0});
        vecs.push_back('{32'h40000000, 32'hFF800000, 32'h80000000, 1'b0});
        vecs.push_back('{32'h00000001, 32'h40000000, 32'h00000000, 1'b0});
        vecs.push_back('{32'h00000003, 32'h40000000, 32'h00000002, 1'b0});
        vecs.push_back('{32'h00800000, 32'h40000000, 32'h00400000, 1'b0});
        vecs.push_back('{32'h7F7FFFFF, 32'h3F000000, 32'h7F800000, 1'b0});
        vecs.push_back('{32'h7FC00000, 32'h3F800000, 32'h7FC00000, 1'b0});
        vecs.push_back('{32'h7F812345, 32'h00000000, 32'h7FC00000, 1'b0});
        vecs.push_back('{32'hFF800000, 32'h40000000, 32'hFF800000, 1'b0});
        vecs.push_back('{32'h80000000, 32'h40000000, 32'h80000000, 1'b0});
        vecs.push_back('{32'hC0000000, 32'h80000000, 32'h7F800000, 1'b1});
        vecs.push_back('{32'h3F800000, 32'h3F800000, 32'h3F800000, 1'b0});

        rstIn   = 1'b0;
        validIn = 1'b0;
        dataAIn = '0;
        dataBIn = '0;
        repeat (3) @(negedge clkIn);
        check("reset ready",    32'(readyOut),   32'd1);
        check("reset valid",    32'(validOut),   32'd0);
        check("reset data",     dataOut,         32'd0);
        check("reset div_zero", 32'(divZeroOut), 32'd0);
        rstIn = 1'b1;
        @(negedge clkIn);

        foreach (vecs[i])
            run_op(vecs[i].a, vecs[i].b, vecs[i].q, vecs[i].dz, $sformatf("vec[%0d]", i));

        // second strobe while busy must be ignored
        wait_ready("busy");
        dataAIn = 32'h40C00000;
        dataBIn = 32'h40000000;
        validIn = 1'b1;
        @(negedge clkIn);
        validIn = 1'b0;
        repeat (5) @(negedge clkIn);
        dataAIn = 32'h3F800000;
        dataBIn = 32'h40400000;
        validIn = 1'b1;
        @(negedge clkIn);
        validIn = 1'b0;
        wait_valid(lat, rdy);
        check("busy latency", 32'(lat + 6), 32'(LAT));
        check("busy data",    dataOut, 32'h40400000);
        pulses = 0;
        repeat (40) begin
            @(negedge clkIn);
            if (validOut) pulses++;
        end
        check("busy extra_pulses", 32'(pulses), 32'd0);

        // leave a nonzero result and divZeroOut=1 behind, then reset mid-operation
        run_op(32'h3F800000, 32'h00000000, 32'h7F800000, 1'b1, "pre_reset");
        dataAIn = 32'h3F800000;
        dataBIn = 32'h3F800000;
        validIn = 1'b1;
        @(negedge clkIn);
        validIn = 1'b0;
        repeat (10) @(negedge clkIn);
        rstIn = 1'b0;
        #1;
        check("midrst ready",    32'(readyOut),   32'd1);
        check("midrst valid",    32'(validOut),   32'd0);
        check("midrst data",     dataOut,         32'd0);
        check("midrst div_zero", 32'(divZeroOut), 32'd0);
        @(negedge clkIn);
        rstIn = 1'b1;
        @(negedge clkIn);
        check("midrst ready_after", 32'(readyOut), 32'd1);
        pulses = 0;
        repeat (40) begin
            @(negedge clkIn);
            if (validOut) pulses++;
        end
        check("midrst no_valid", 32'(pulses), 32'd0);
        check("midrst data_end", dataOut, 32'd0);

        // validIn held high: back-to-back acceptance in the validOut cycle,
        // operands wiggling while busy must not matter
        dataAIn = 32'h3F800000;
        dataBIn = 32'h40400000;
        validIn = 1'b1;
        @(negedge clkIn);
        lat = 0;
        while (validOut !== 1'b1 && lat < TMO) begin
            dataAIn = $urandom;
            dataBIn = $urandom;
            @(negedge clkIn);
            lat++;
        end
        check("b2b op1 latency", 32'(lat), 32'(LAT));
        check("b2b op1 data",    dataOut, 32'h3EAAAAAB);
        check("b2b op1 ready",   32'(readyOut), 32'd1);
        dataAIn = 32'h40C00000;
        dataBIn = 32'h40000000;
        @(negedge clkIn);
        check("b2b op2 accepted", 32'(readyOut), 32'd0);
        lat = 0;
        while (validOut !== 1'b1 && lat < TMO) begin
            dataAIn = $urandom;
            dataBIn = $urandom;
            @(negedge clkIn);
            lat++;
        end
        check("b2b op2 latency", 32'(lat), 32'(LAT));
        check("b2b op2 data",    dataOut, 32'h40400000);
        dataAIn = 32'hBF800000;
        dataBIn = 32'h40400000;
        @(negedge clkIn);
        validIn = 1'b0;
        wait_valid(lat, rdy);
        check("b2b op3 latency", 32'(lat), 32'(LAT));
        check("b2b op3 data",    dataOut, 32'hBEAAAAAB);
        @(negedge clkIn);

        for (int i = 0; i < 200; i++) begin
            a = rand_op();
            b = rand_op();
            q = model_div(a, b, dz);
            run_op(a, b, q, dz, $sformatf("rnd[%0d] %h/%h", i, a, b));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
